// File: rtl/sync_ptr_bank.sv
// Purpose: bring CHANNELS Gray FIFO pointers into dest_clk, with binary copies, update pulses and Gray-violation flags.
// Latency: dest_ptr_gray STAGES cycles after sampling; dest_ptr_bin, ptr_update STAGES+1; gray_err STAGES+1.
// Backpressure: none. Every dest_clk cycle is processed; the source must change at most one Gray bit per source cycle.
module sync_ptr_bank #(
    parameter int ASIZE    = 4,
    parameter int CHANNELS = 1,
    parameter int STAGES   = 2
) (
    input  logic                           dest_clk,
    input  logic                           dest_rst_n,
    input  logic [CHANNELS*(ASIZE+1)-1:0]  src_ptr,
    input  logic                           err_clr,
    output logic [CHANNELS*(ASIZE+1)-1:0]  dest_ptr_gray,
    output logic [CHANNELS*(ASIZE+1)-1:0]  dest_ptr_bin,
    output logic [CHANNELS-1:0]            ptr_update,
    output logic [CHANNELS-1:0]            gray_err
);

    localparam int PW = ASIZE + 1;

    // Fewer than two stages gives no metastability protection; more than four
    // only adds latency the FIFOs were never sized for.
    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("sync_ptr_bank: STAGES must be in 2..4");
        end
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("sync_ptr_bank: CHANNELS must be in 1..8");
        end
    endgenerate

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b         = '0;
        b[PW-1]   = g[PW-1];
        for (int j = PW - 2; j >= 0; j--) begin
            b[j] = b[j+1] ^ g[j];
        end
        return b;
    endfunction

    // True when two codes differ in two or more bit positions.
    function automatic logic multi_bit_change(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] diff;
        diff = a ^ b;
        // Clearing the lowest set bit leaves something only if more than one bit was set.
        return |(diff & (diff - PW'(1)));
    endfunction

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            logic [PW-1:0] sync_q [STAGES];
            logic [PW-1:0] gray_cur;
            logic [PW-1:0] gray_prev_q;
            logic [PW-1:0] bin_next;
            logic [PW-1:0] bin_q;
            logic          upd_q;
            logic          err_q;
            logic          viol;

            // Synchroniser chain: stage 0 alone samples the foreign-domain bits,
            // the remaining stages are plain flop-to-flop with no logic between.
            always_ff @(posedge dest_clk or negedge dest_rst_n) begin
                if (!dest_rst_n) begin
                    for (int k = 0; k < STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    sync_q[0] <= src_ptr[c*PW +: PW];
                    for (int k = 1; k < STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign gray_cur = sync_q[STAGES-1];

            // Combinational decode of the synchronised pointer and the step check.
            always_comb begin
                bin_next = gray_to_bin(gray_cur);
                viol     = multi_bit_change(gray_cur, gray_prev_q);
            end

            // Registered binary pointer, its change pulse, and the Gray history
            // used by the step check one cycle later.
            always_ff @(posedge dest_clk or negedge dest_rst_n) begin
                if (!dest_rst_n) begin
                    gray_prev_q <= '0;
                    bin_q       <= '0;
                    upd_q       <= 1'b0;
                end else begin
                    gray_prev_q <= gray_cur;
                    bin_q       <= bin_next;
                    upd_q       <= (bin_next != bin_q);
                end
            end

            // Sticky violation flag; a fresh violation beats a simultaneous clear.
            always_ff @(posedge dest_clk or negedge dest_rst_n) begin
                if (!dest_rst_n) begin
                    err_q <= 1'b0;
                end else begin
                    err_q <= (err_q & ~err_clr) | viol;
                end
            end

            assign dest_ptr_gray[c*PW +: PW] = gray_cur;
            assign dest_ptr_bin[c*PW +: PW]  = bin_q;
            assign ptr_update[c]             = upd_q;
            assign gray_err[c]               = err_q;
        end
    endgenerate

endmodule

// File: doc/sync_ptr_bank.md
Name: sync_ptr_bank

Overview:
Multi-channel, depth-configurable Gray-pointer synchroniser for the async FIFOs in the debug subsystem. It brings CHANNELS independent (ASIZE+1)-bit Gray pointers from foreign clock domains into dest_clk through a STAGES-deep flop chain. It also produces registered binary equivalents and per-channel update pulses. Each channel has a sticky Gray-coding-violation flag that catches source pointers not changing one bit at a time.

Parameters:
ASIZE, 4, FIFO address width; each pointer is ASIZE+1 bits (MSB = wrap bit)
CHANNELS, 1, number of independent pointers synchronised (1..8)
STAGES, 2, synchroniser flop depth per bit (legal 2..4; elaboration error otherwise)

Ports:
dest_clk  in  1  destination clock
dest_rst_n  in  1  async active-low reset
src_ptr  in  CHANNELS*(ASIZE+1)  Gray pointers from source domains; channel i = bits [i*(ASIZE+1) +: ASIZE+1]
err_clr  in  1  synchronous clear of all gray_err flags (dest_clk domain)
dest_ptr_gray  out  CHANNELS*(ASIZE+1)  synchronised Gray pointers, same packing as src_ptr
dest_ptr_bin  out  CHANNELS*(ASIZE+1)  registered binary conversion of dest_ptr_gray
ptr_update  out  CHANNELS  1-cycle pulse when that channel's dest_ptr_bin changed this cycle
gray_err  out  CHANNELS  sticky flag: synchronised Gray value jumped by more than one bit

Behaviour:
- Clock and reset: reset dest_rst_n, asynchronous, active-low; clock dest_clk. All flops are in the dest_clk domain. There is no source-side logic.
- Reset: all synchroniser stages, dest_ptr_gray, dest_ptr_bin, ptr_update, gray_err and the internal history registers are 0. Deassertion takes effect on the next dest_clk edge.
- Reset mid-operation: all state returns to 0 immediately. No update pulse is generated for the reset-induced change.
- Sync chain: per channel, stage[0] <= src_ptr slice; stage[k] <= stage[k-1]. dest_ptr_gray = stage[STAGES-1].
  - A stable source change appears on dest_ptr_gray exactly STAGES dest_clk edges after it is sampled.
  - Stage 0 is the only flop that sees asynchronous data; no logic sits between stages.
- Binary conversion: bin[ASIZE] = g[ASIZE]; bin[j] = bin[j+1] ^ g[j]. The result is registered, so dest_ptr_bin lags dest_ptr_gray by 1 cycle. Total latency is STAGES+1 cycles.
- Update pulse: ptr_update[i] is registered and asserts in the same cycle the new dest_ptr_bin value first appears. The rule is ptr_update[i] <= (next bin != current dest_ptr_bin). The pulse lasts 1 cycle per change. Back-to-back changes give back-to-back pulses.
- Gray check: each cycle, compare dest_ptr_gray with its value on the previous cycle.
  - Hamming distance 0 or 1: legal.
  - Hamming distance ≥2: set gray_err[i] on the next edge.
  - Wrap-around (for example 5'b10000 -> 5'b00000) is a single-bit change and is legal.
- err_clr: clears all gray_err bits on the next edge. If a new violation is detected in the same cycle that err_clr is asserted, set wins and the bit stays 1.
- Channels are fully independent. Simultaneous changes on several channels are processed in parallel with no arbitration.
- The block carries no valid or handshake signal. Correctness relies on the source updating at most one Gray bit per source cycle. gray_err is diagnostic only and does not alter any data path.

Test Plan:
- Reset/latency, STAGES=2, CHANNELS=1: deassert reset, drive src_ptr 00000->00001 -> dest_ptr_gray=00001 after 2 edges; dest_ptr_bin=00001 and ptr_update=1 for exactly 1 cycle on edge 3; gray_err=0.
- STAGES=3, Gray count through all 32 codes including wrap 10000->00000 -> dest_ptr_bin steps 0..31 then 0, each value 4 edges after its source value; 32 ptr_update pulses; gray_err stays 0.
- Violation: jump src_ptr 00000->00011 -> gray_err=1 at STAGES+1 edges and holds. Pulse err_clr -> gray_err=0 the next cycle. Repeat with err_clr asserted in the detection cycle -> gray_err stays 1.
- CHANNELS=3, simultaneous change: ch0 00001, ch1 00011, ch2 00010 -> bin outputs 1, 2, 3 on the same edge; ptr_update=3'b111 for one cycle.
- Async reset mid-traffic: assert dest_rst_n low between edges while pointers ≠ 0 -> all outputs 0 immediately; after release with a stable src, outputs reappear after STAGES(+1) edges.
- Hold: src_ptr constant for 20 cycles -> no ptr_update pulses; dest_ptr_gray equals src_ptr.
